bumpy_fsm: RTL



---
 rtl/bumpy_fsm_if.sv | 32 +++
 rtl/bumpy_fsm.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bumpy_fsm_if.sv
// Signal bundle between the Bumpy behaviour controller and its environment.
// The master side drives frame, key and collision inputs; the slave side (the FSM) returns state and lives.
interface bumpy_fsm_if;
    logic       startOfFrame;
    logic       restart;
    logic       leftIsPressed;
    logic       rightIsPressed;
    logic       upIsPressed;
    logic       downIsPressed;
    logic       col_wall_left;
    logic       col_wall_right;
    logic       col_ceiling;
    logic       col_hazard;
    logic [3:0] state;
    logic [2:0] lives;
    logic       game_over;
    logic       die_pulse;

    modport master (
        output startOfFrame, restart,
        output leftIsPressed, rightIsPressed, upIsPressed, downIsPressed,
        output col_wall_left, col_wall_right, col_ceiling, col_hazard,
        input  state, lives, game_over, die_pulse
    );

    modport slave (
        input  startOfFrame, restart,
        input  leftIsPressed, rightIsPressed, upIsPressed, downIsPressed,
        input  col_wall_left, col_wall_right, col_ceiling, col_hazard,
        output state, lives, game_over, die_pulse
    );
endinterface

// File: rtl/bumpy_fsm.sv
// Frame-paced behaviour controller for the Bumpy sprite: one state decision per startOfFrame, plus lives/game-over.
// Optional feature macro: BUMPY_FSM_STICKY_COLLISION_EN (holds collision pulses until the next frame decision).
module bumpy_fsm #(
    parameter int unsigned BOUNCE_FRAMES = 8,
    parameter int unsigned DIE_FRAMES    = 60,
    parameter int unsigned RESET_FRAMES  = 2,
    parameter int unsigned LIVES         = 3
) (
    input  logic        clk,
    input  logic        resetN,
    bumpy_fsm_if.slave  bus
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIVES_W = 3;
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   RESET_LAST  = CNT_W'(RESET_FRAMES - 1);
    localparam logic [CNT_W-1:0]   BOUNCE_LAST = CNT_W'(BOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   DIE_LAST    = CNT_W'(DIE_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);

    typedef enum logic [3:0] {
        ST_RESET        = 4'd0,
        ST_IDLE         = 4'd1,
        ST_LEFT         = 4'd2,
        ST_RIGHT        = 4'd3,
        ST_DOWN         = 4'd4,
        ST_UP           = 4'd5,
        ST_DIE          = 4'd6,
        ST_BOUNCE_LEFT  = 4'd7,
        ST_BOUNCE_RIGHT = 4'd8,
        ST_BOUNCE_TOP   = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 game_over_q, game_over_d;
    logic                 die_pulse_q, die_pulse_d;

    // Collision vector order: {hazard, ceiling, wall_right, wall_left}
    logic [3:0] col_in;
    logic [3:0] col_eff;

    assign col_in = {bus.col_hazard, bus.col_ceiling, bus.col_wall_right, bus.col_wall_left};

`ifdef BUMPY_FSM_STICKY_COLLISION_EN
    logic [3:0] col_lat_q;

    // Latches gather pulses through the frame; the frame decision consumes and clears them.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            col_lat_q <= 4'd0;
        end else if (bus.restart || bus.startOfFrame) begin
            col_lat_q <= 4'd0;
        end else begin
            col_lat_q <= col_lat_q | col_in;
        end
    end

    assign col_eff = col_lat_q | col_in;
`else
    assign col_eff = col_in;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
            die_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            die_pulse_q <= die_pulse_d;
        end
    end

    // Next-state decision; restart beats any frame decision
    always_comb begin
        state_d = state_q;
        if (bus.restart) begin
            state_d = ST_RESET;
        end else if (bus.startOfFrame) begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) state_d = ST_IDLE;
                end
                ST_IDLE, ST_LEFT, ST_RIGHT, ST_DOWN, ST_UP: begin
                    if      (col_eff[3])         state_d = ST_DIE;
                    else if (col_eff[0])         state_d = ST_BOUNCE_LEFT;
                    else if (col_eff[1])         state_d = ST_BOUNCE_RIGHT;
                    else if (col_eff[2])         state_d = ST_BOUNCE_TOP;
                    else if (bus.leftIsPressed)  state_d = ST_LEFT;
                    else if (bus.rightIsPressed) state_d = ST_RIGHT;
                    else if (bus.upIsPressed)    state_d = ST_UP;
                    else if (bus.downIsPressed)  state_d = ST_DOWN;
                    else                         state_d = ST_IDLE;
                end
                ST_BOUNCE_LEFT, ST_BOUNCE_RIGHT, ST_BOUNCE_TOP: begin
                    if      (col_eff[3])          state_d = ST_DIE;
                    else if (cnt_q == BOUNCE_LAST) state_d = ST_IDLE;
                end
                ST_DIE: begin
                    if (cnt_q == DIE_LAST && lives_q != '0) state_d = ST_RESET;
                end
                default: state_d = ST_RESET;
            endcase
        end
    end

    // Frame counter, lives and status flags derived from the transition
    always_comb begin
        cnt_d       = cnt_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        die_pulse_d = 1'b0;
        if (bus.restart) begin
            cnt_d       = '0;
            lives_d     = LIVES_INIT;
            game_over_d = 1'b0;
        end else begin
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (bus.startOfFrame && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (state_d == ST_DIE && state_q != ST_DIE) begin
                die_pulse_d = 1'b1;
                if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
            end
            // Counter saturates, so the timeout match fires exactly once per Sdie stay
            if (state_q == ST_DIE && bus.startOfFrame && cnt_q == DIE_LAST && lives_q == '0) begin
                game_over_d = 1'b1;
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
    assign bus.die_pulse = die_pulse_q;
endmodule
